// File: rtl/cmp_report_tx.sv
// UART 8N1 transmitter that sends one comparator result as an 11-byte ASCII line:
// "AA BB M R\r\n", where AA/BB are the operands in uppercase hex.
module cmp_report_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       mode,
    input  logic       result,
    output logic       tx,
    output logic       busy,
    output logic       done_tick
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BYTE = 4'd10;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [3:0]        byte_q, byte_d;
    logic [7:0]        a_q, a_d, b_q, b_d;
    logic              mode_q, mode_d, result_q, result_d;
    logic              tx_q, tx_d, done_q, done_d;

    logic [7:0] cur_byte;
    logic [2:0] next_bit;
    logic       bit_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // The byte index stays constant for a whole byte, so the line content is a plain mux.
    always_comb begin
        case (byte_q)
            4'd0:    cur_byte = hex_ascii(a_q[7:4]);
            4'd1:    cur_byte = hex_ascii(a_q[3:0]);
            4'd3:    cur_byte = hex_ascii(b_q[7:4]);
            4'd4:    cur_byte = hex_ascii(b_q[3:0]);
            4'd6:    cur_byte = mode_q ? 8'h53 : 8'h55;
            4'd8:    cur_byte = result_q ? 8'h31 : 8'h30;
            4'd9:    cur_byte = 8'h0D;
            4'd10:   cur_byte = 8'h0A;
            default: cur_byte = 8'h20;
        endcase
    end

    assign bit_end  = (baud_q == BAUD_LAST);
    assign next_bit = bit_q + 3'd1;

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        result_d = result_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        baud_d   = (state_q == IDLE || bit_end) ? '0 : baud_q + BAUD_W'(1);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d  = START;
                    tx_d     = 1'b0;
                    byte_d   = 4'd0;
                    bit_d    = 3'd0;
                    a_d      = a;
                    b_d      = b;
                    mode_d   = mode;
                    result_d = result;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_d = next_bit;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = cur_byte[next_bit];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                        byte_d  = 4'd0;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = START;
                        byte_d  = byte_q + 4'd1;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 4'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            mode_q   <= 1'b0;
            result_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE);
    assign done_tick = done_q;

endmodule

// File: tb/tb_cmp_report_tx.sv
// Bench for cmp_report_tx: a UART decoder pops expected bytes from a scoreboard queue,
// while the main sequence checks frame timing, busy rejection, back-to-back and reset abort.
module tb_cmp_report_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       mode, result;
    logic       tx, busy, done_tick;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic             mode;
        logic             result;
        logic [0:10][7:0] exp;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];

    logic [7:0] rx_byte;
    logic       rx_stop;
    logic [7:0] rx_exp;
    bit         rx_abort;

    cmp_report_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .result    (result),
        .tx        (tx),
        .busy      (busy),
        .done_tick (done_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (done_tick === 1'b1) done_cnt++;

    // UART decoder: sampling on negedges lands half a cycle into each bit.
    always begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx === 1'b0) begin
            rx_abort = 1'b0;
            for (int i = 0; i < 9; i++) begin
                repeat (CPB) @(negedge clk);
                if (rst_n !== 1'b1) begin
                    rx_abort = 1'b1;
                    break;
                end
                if (i < 8) rx_byte[i] = tx;
                else       rx_stop    = tx;
            end
            if (!rx_abort) begin
                check("rx_stop_bit", {31'd0, rx_stop}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected_byte actual=%0h expected=none", rx_byte);
                end else begin
                    rx_exp = exp_q.pop_front();
                    check("rx_byte", {24'd0, rx_byte}, {24'd0, rx_exp});
                end
            end
        end
    end

    // Called at a negedge: present operands, raise start, queue the expected line.
    task automatic drive_frame(input vec_t v);
        a      = v.a;
        b      = v.b;
        mode   = v.mode;
        result = v.result;
        start  = 1'b1;
        for (int i = 0; i < 11; i++) exp_q.push_back(v.exp[i]);
    endtask

    // n counts negedges after the accepting edge; disturb adds a rejected start and input churn.
    task automatic wait_done(input bit disturb, output int n_done, output int n_low, output int busy1);
        n_done = -1;
        n_low  = -1;
        busy1  = -1;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                busy1 = int'(busy);
            end
            if (n_low < 0 && tx === 1'b0) n_low = n;
            if (disturb && n == 50) start = 1'b1;
            if (disturb && n == 51) start = 1'b0;
            if (disturb && n == 100) begin
                a      = 8'($urandom);
                b      = 8'($urandom);
                mode   = ~mode;
                result = ~result;
            end
            if (done_tick === 1'b1) begin
                n_done = n;
                break;
            end
        end
        if (n_done < 0) $display("FAIL done_timeout actual=none expected=done_tick");
    endtask

    int nd, nl, b1, d0;

    initial begin
        vecs[0] = '{a: 8'hA5, b: 8'h3C, mode: 1'b1, result: 1'b1,
                    exp: {8'h41, 8'h35, 8'h20, 8'h33, 8'h43, 8'h20, 8'h53, 8'h20, 8'h31, 8'h0D, 8'h0A}};
        vecs[1] = '{a: 8'h00, b: 8'hFF, mode: 1'b0, result: 1'b0,
                    exp: {8'h30, 8'h30, 8'h20, 8'h46, 8'h46, 8'h20, 8'h55, 8'h20, 8'h30, 8'h0D, 8'h0A}};
        vecs[2] = '{a: 8'h9F, b: 8'h60, mode: 1'b0, result: 1'b1,
                    exp: {8'h39, 8'h46, 8'h20, 8'h36, 8'h30, 8'h20, 8'h55, 8'h20, 8'h31, 8'h0D, 8'h0A}};
        vecs[3] = '{a: 8'h12, b: 8'h34, mode: 1'b0, result: 1'b0,
                    exp: {8'h31, 8'h32, 8'h20, 8'h33, 8'h34, 8'h20, 8'h55, 8'h20, 8'h30, 8'h0D, 8'h0A}};
        vecs[4] = '{a: 8'h7E, b: 8'h81, mode: 1'b1, result: 1'b0,
                    exp: {8'h37, 8'h45, 8'h20, 8'h38, 8'h31, 8'h20, 8'h53, 8'h20, 8'h30, 8'h0D, 8'h0A}};

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        mode   = 1'b0;
        result = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = ~start;
            a     = 8'($urandom);
            check("reset_hold_idle", {29'd0, tx, busy, done_tick}, 32'b100);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {29'd0, tx, busy, done_tick}, 32'b100);

        // Table frames, each with a rejected mid-frame start and mid-frame input changes.
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt;
            drive_frame(vecs[i]);
            wait_done(1'b1, nd, nl, b1);
            check("busy_after_accept", b1, 1);
            check("first_tx_low", nl, 1);
            check("done_latency", nd, 441);
            check("frame_len", nd - nl, 440);
            repeat (500) @(negedge clk);
            check("bytes_left", exp_q.size(), 0);
            check("done_count", done_cnt - d0, 1);
            check("idle_after", {30'd0, tx, busy}, 32'b10);
        end

        // Back-to-back: second start raised in the done_tick cycle.
        drive_frame(vecs[0]);
        wait_done(1'b0, nd, nl, b1);
        check("b2b_first_done", nd, 441);
        drive_frame(vecs[3]);
        wait_done(1'b0, nd, nl, b1);
        check("b2b_first_low", nl, 1);
        check("b2b_busy", b1, 1);
        check("b2b_second_done", nd, 441);
        repeat (20) @(negedge clk);
        check("b2b_bytes_left", exp_q.size(), 0);

        // Reset asserted during the third byte aborts the frame.
        d0 = done_cnt;
        drive_frame(vecs[2]);
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort_tx_high", {31'd0, tx}, 32'd1);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", {29'd0, tx, busy, done_tick}, 32'b100);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        drive_frame(vecs[4]);
        wait_done(1'b0, nd, nl, b1);
        check("after_abort_done", nd, 441);
        check("after_abort_len", nd - nl, 440);
        repeat (20) @(negedge clk);
        check("after_abort_bytes_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmp_report_tx.md
Name: cmp_report_tx

Overview:
- UART transmitter that reports one comparator result as an 11-byte ASCII line.
- A one-cycle start tick, typically the debounced button tick, snapshots the a/b operands, the comparison mode and the comparison result.
- The frame is serialised 8N1, LSB first, on a single tx pin.
- It is the outbound counterpart to the switch/button input path of the dual-mode comparator board; the line goes to the host terminal.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (active when 0).
- start  input  1  one-cycle request tick; accepted only when busy=0.
- a  input  8  operand A, sampled on acceptance.
- b  input  8  operand B, sampled on acceptance.
- mode  input  1  1 = signed comparison, 0 = unsigned; sampled on acceptance.
- result  input  1  comparator output; sampled on acceptance.
- tx  output  1  serial line; idles high.
- busy  output  1  high from the cycle after acceptance until the frame ends.
- done_tick  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values (reset=0, asynchronous): tx=1, busy=0, done_tick=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame: tx returns high at once and no done_tick is produced.
- Acceptance: start=1 while in IDLE (busy=0) captures a, b, mode and result into internal registers.
  - Later input changes have no effect on the frame in progress.
  - start while busy=1 is ignored; it is not queued.
- Frame content, 11 bytes in this order:
  - hex(a[7:4]), hex(a[3:0]), 0x20,
  - hex(b[7:4]), hex(b[3:0]), 0x20,
  - 'S' (0x53) if mode=1 else 'U' (0x55), 0x20,
  - '1' (0x31) if result=1 else '0' (0x30),
  - 0x0D, 0x0A.
- Hex digits are uppercase: 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
- Byte encoding: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held on tx for exactly CLKS_PER_BIT cycles.
  - There are no idle bits between bytes.
- State machine:
  - IDLE -> START on acceptance. tx goes low on the first clock edge after the start cycle (latency 1).
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bit periods. A 3-bit bit index wraps 7 -> 0.
  - STOP -> START of the next byte when the byte index is < 10.
  - STOP -> IDLE when the byte index is 10. A 4-bit byte index counts 0..10.
- Frame length: 110*CLKS_PER_BIT cycles from the first tx-low cycle to the end of the last stop bit.
- Frame end: in the cycle after the final stop period, done_tick=1, busy=0 and state=IDLE.
  - A start in that same cycle is accepted, giving back-to-back frames with no idle gap beyond that one cycle.
- The baud counter counts 0..CLKS_PER_BIT-1 and resets at every bit boundary. Its width is clog2(CLKS_PER_BIT).
- busy=1 in every cycle while state != IDLE.

Test Plan:
- Reset with CLKS_PER_BIT=4 -> tx=1, busy=0, done_tick=0. Hold reset for 10 cycles with start pulsing -> no activity.
- Basic frame: a=0xA5, b=0x3C, mode=1, result=1, start pulse -> bench UART decoder receives 41 35 20 33 43 20 53 20 31 0D 0A.
  - Frame lasts 440 cycles.
  - done_tick occurs exactly once, at cycle 441 after acceptance.
- Unsigned/zero frame: a=0x00, b=0xFF, mode=0, result=0 -> bytes 30 30 20 46 46 20 55 20 30 0D 0A.
  - Change a, b and mode mid-frame -> frame unchanged.
- Busy rejection: pulse start 50 cycles into a frame -> exactly one frame is sent and no second frame follows.
- Back-to-back: assert start in the done_tick cycle with a=0x12 -> second frame starts on the next edge. Its first bytes are 31 32.
- Reset mid-frame: drive reset=0 during the 3rd byte -> tx=1 immediately, busy=0, no done_tick.
  - After release, a new start produces a complete, correct frame.
